// File: rtl/round_robin_arbiter_pkg.sv
// Shared definitions for the round-robin arbiter: state encoding and sizing helpers.
// Used by the RTL and by the testbench.
package round_robin_arbiter_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic int num_req(input int width);
        return 1 << width;
    endfunction

    // Counter only has to reach MAX_HOLD-1; keep at least one bit for MAX_HOLD of 0 or 1.
    function automatic int hold_cnt_width(input int max_hold);
        return (max_hold < 2) ? 1 : $clog2(max_hold);
    endfunction

endpackage

// File: rtl/round_robin_arbiter_grant_decoder.sv
// Binary grant index to one-hot grant vector, forced to zero while no grant is active.
module grant_decoder
    import round_robin_arbiter_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic [WIDTH-1:0]          idx_i,
    input  logic                      en_i,
    output logic [num_req(WIDTH)-1:0] grant_o
);

    always_comb begin
        grant_o = '0;
        if (en_i) begin
            grant_o[idx_i] = 1'b1;
        end
    end

endmodule

// File: rtl/round_robin_arbiter.sv
// Round-robin arbiter with explicit release, optional hold limit and zero-gap handover.
//   state | meaning
//   IDLE  | no owner, scan from pointer on any request
//   BUSY  | owner held until release or hold-limit timeout
module round_robin_arbiter
    import round_robin_arbiter_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic                      iClk,
    input  logic                      iRst,
    input  logic [num_req(WIDTH)-1:0] iReq,
    input  logic                      iRelease,
    output logic                      oValid,
    output logic [WIDTH-1:0]          oGrantIdx,
    output logic [num_req(WIDTH)-1:0] oGrant,
    output logic                      oTimeout
);

    localparam int N  = num_req(WIDTH);
    localparam int CW = hold_cnt_width(MAX_HOLD);
    localparam logic [CW-1:0] HOLD_LAST = CW'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);

    state_e          state_q, state_d;
    logic [WIDTH-1:0] ptr_q, ptr_d;
    logic [WIDTH-1:0] idx_q, idx_d;
    logic            valid_q, valid_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            busy;
    logic            limit_hit;
    logic            timeout;
    logic            release_now;
    logic [WIDTH-1:0] scan_base;
    logic [WIDTH-1:0] cand;
    logic [WIDTH-1:0] scan_idx;
    logic            scan_hit;

    assign busy        = (state_q == BUSY);
    assign limit_hit   = (MAX_HOLD > 0) && busy && (cnt_q == HOLD_LAST);
    assign timeout     = limit_hit && !iRelease && !iRst;
    assign release_now = busy && (iRelease || limit_hit);

    // Scanning from owner+1 while busy puts the releasing owner last in line.
    assign scan_base = busy ? (idx_q + WIDTH'(1)) : ptr_q;

    always_comb begin
        scan_hit = 1'b0;
        scan_idx = '0;
        cand     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            cand = scan_base + WIDTH'(k);
            if (iReq[cand]) begin
                scan_hit = 1'b1;
                scan_idx = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (scan_hit) begin
                    state_d = BUSY;
                    idx_d   = scan_idx;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                if (release_now) begin
                    ptr_d = idx_q + WIDTH'(1);
                    cnt_d = '0;
                    if (scan_hit) begin
                        idx_d = scan_idx;
                    end else begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign oValid    = valid_q;
    assign oGrantIdx = idx_q;
    assign oTimeout  = timeout;

    grant_decoder #(
        .WIDTH (WIDTH)
    ) u_grant_decoder (
        .idx_i   (idx_q),
        .en_i    (valid_q),
        .grant_o (oGrant)
    );

endmodule

// File: tb/tb_round_robin_arbiter.sv
// Scoreboard bench for round_robin_arbiter at WIDTH=2, MAX_HOLD=4: directed scenarios then random traffic.
module tb_round_robin_arbiter;
    import round_robin_arbiter_pkg::*;

    localparam int WIDTH    = 2;
    localparam int MAX_HOLD = 4;
    localparam int N        = num_req(WIDTH);

    typedef struct packed {
        logic             v;
        logic [WIDTH-1:0] idx;
        logic [N-1:0]     g;
    } exp_t;

    logic             clk = 1'b0;
    logic             iRst = 1'b1;
    logic [N-1:0]     iReq = '0;
    logic             iRelease = 1'b0;
    logic             oValid;
    logic [WIDTH-1:0] oGrantIdx;
    logic [N-1:0]     oGrant;
    logic             oTimeout;

    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic last_tmo;

    int   m_valid, m_idx, m_ptr, m_cnt;

    always #5 clk = ~clk;

    round_robin_arbiter #(
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .iClk      (clk),
        .iRst      (iRst),
        .iReq      (iReq),
        .iRelease  (iRelease),
        .oValid    (oValid),
        .oGrantIdx (oGrantIdx),
        .oGrant    (oGrant),
        .oTimeout  (oTimeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic pick(input logic [N-1:0] req);
        int j;
        j = m_ptr;
        while (!req[j]) j = (j + 1) % N;
        m_idx   = j;
        m_valid = 1;
        m_cnt   = 0;
    endtask

    // Advances the reference model across one clock edge; tmo is the pulse expected in this cycle.
    task automatic model(input logic [N-1:0] req, input logic rel, input logic rst, output logic tmo);
        logic fin;
        tmo = 1'b0;
        if (rst) begin
            m_valid = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;
        end else if (m_valid == 0) begin
            if (req != '0) pick(req);
        end else begin
            tmo = (m_cnt == MAX_HOLD - 1) && !rel;
            fin = rel || tmo;
            if (fin) begin
                m_ptr = (m_idx + 1) % N;
                if (req != '0) pick(req);
                else begin
                    m_valid = 0;
                    m_cnt   = 0;
                end
            end else begin
                m_cnt++;
            end
        end
    endtask

    task automatic step(input logic [N-1:0] req, input logic rel, input logic rst);
        exp_t e;
        logic tmo_exp;
        @(negedge clk);
        iReq = req; iRelease = rel; iRst = rst;
        #1;
        model(req, rel, rst, tmo_exp);
        last_tmo = oTimeout;
        chk("timeout", 32'(oTimeout), 32'(tmo_exp));
        e.v   = (m_valid != 0);
        e.idx = WIDTH'(m_idx);
        e.g   = (m_valid != 0) ? N'(1 << m_idx) : '0;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            n_vec++; n_err++;
            $display("FAIL scoreboard: got empty queue expected one entry");
        end else begin
            e = sb.pop_front();
            chk("valid", 32'(oValid), 32'(e.v));
            chk("grant", 32'(oGrant), 32'(e.g));
            if (e.v) chk("idx", 32'(oGrantIdx), 32'(e.idx));
        end
    endtask

    initial begin
        m_valid = 0; m_idx = 0; m_ptr = 0; m_cnt = 0;

        // reset state
        step(4'b0000, 1'b0, 1'b1);
        chk("rst_valid", 32'(oValid), 0);
        chk("rst_grant", 32'(oGrant), 0);
        chk("rst_idx", 32'(oGrantIdx), 0);

        // first grant from pointer 0 picks lowest set bit
        step(4'b1010, 1'b0, 1'b0);
        chk("r028_idx", 32'(oGrantIdx), 1);
        chk("r028_grant", 32'(oGrant), 32'b0010);
        step(4'b1010, 1'b1, 1'b0);
        chk("r028_next", 32'(oGrantIdx), 3);

        // full rotation with zero-gap handover
        step(4'b0000, 1'b0, 1'b1);
        step(4'b1111, 1'b0, 1'b0);
        chk("rot_0", 32'(oGrantIdx), 0);
        for (int i = 1; i <= 4; i++) begin
            step(4'b1111, 1'b1, 1'b0);
            chk("rot_valid", 32'(oValid), 1);
            chk("rot_idx", 32'(oGrantIdx), 32'(i % 4));
        end

        // wrap from owner 3, then sole requester regrants itself
        for (int i = 0; i < 3; i++) step(4'b1111, 1'b1, 1'b0);
        chk("wrap_own3", 32'(oGrantIdx), 3);
        step(4'b0011, 1'b1, 1'b0);
        chk("wrap_idx0", 32'(oGrantIdx), 0);
        step(4'b0001, 1'b1, 1'b0);
        chk("wrap_regrant", 32'(oGrantIdx), 0);
        chk("wrap_valid", 32'(oValid), 1);

        // hold-limit timeout on owner 2
        step(4'b0000, 1'b0, 1'b1);
        step(4'b0100, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(4'b0100, 1'b0, 1'b0);
            chk("tmo_early", 32'(last_tmo), 0);
        end
        step(4'b0100, 1'b0, 1'b0);
        chk("tmo_4th", 32'(last_tmo), 1);
        chk("tmo_regrant", 32'(oGrantIdx), 2);
        step(4'b0100, 1'b0, 1'b0);
        chk("tmo_cleared", 32'(last_tmo), 0);

        // release coinciding with the limit is a normal release
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0100, 1'b0, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        chk("tmo_with_rel", 32'(last_tmo), 0);
        chk("rel_to_idle", 32'(oValid), 0);

        // reset mid-grant
        step(4'b1000, 1'b0, 1'b0);
        chk("pre_rst_idx", 32'(oGrantIdx), 3);
        step(4'b1000, 1'b0, 1'b1);
        chk("mid_rst_tmo", 32'(last_tmo), 0);
        chk("mid_rst_valid", 32'(oValid), 0);
        chk("mid_rst_grant", 32'(oGrant), 0);
        step(4'b1111, 1'b0, 1'b0);
        chk("post_rst_idx", 32'(oGrantIdx), 0);

        // owner dropping its request keeps the grant; release in IDLE is ignored
        step(4'b1110, 1'b0, 1'b0);
        chk("drop_hold", 32'(oGrantIdx), 0);
        chk("drop_valid", 32'(oValid), 1);
        step(4'b0000, 1'b1, 1'b0);
        step(4'b0000, 1'b1, 1'b0);
        chk("idle_rel", 32'(oValid), 0);
        step(4'b0011, 1'b0, 1'b0);
        chk("idle_rel_ptr", 32'(oGrantIdx), 1);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            step(N'($urandom_range(0, 15)),
                 ($urandom_range(0, 3) == 0),
                 ($urandom_range(0, 63) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
